// File: rtl/count_stream_decoder.sv
// Recovers enable/direction steps from a sampled up/down counter value stream,
// flags wrap-around and illegal jumps, and tracks lock. Optional stall check: DECODER_STALL_CHECK_EN.
module count_stream_decoder #(
  parameter int WIDTH       = 8,
  parameter int RESYNC_LEN  = 4,
  parameter int STALL_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             valid_in,
  output logic             enable_out,
  output logic             direction_out,
  output logic             wrap_out,
  output logic             err_out,
  output logic             locked,
  output logic [7:0]       err_cnt,
  output logic             stall_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_VAL    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]       RESYNC_TGT = 4'(RESYNC_LEN);

  state_t           state_r;
  logic [WIDTH-1:0] prev_r;
  logic [3:0]       resync_r;
  logic [WIDTH-1:0] delta_s;
  logic             is_zero_s;
  logic             is_up_s;
  logic             is_dn_s;
  logic             legal_s;
  logic [3:0]       resync_inc_s;
  logic [7:0]       err_cnt_inc_s;

  // Delta classification against the previous sample.
  always_comb begin
    delta_s       = count_in - prev_r;
    is_zero_s     = (delta_s == ZERO_VAL);
    is_up_s       = (delta_s == ONE_VAL);
    is_dn_s       = (delta_s == MAX_VAL);
    legal_s       = is_zero_s | is_up_s | is_dn_s;
    resync_inc_s  = resync_r + 4'd1;
    if (err_cnt == 8'hFF) begin
      err_cnt_inc_s = err_cnt;
    end else begin
      err_cnt_inc_s = err_cnt + 8'd1;
    end
  end

  // Lock FSM with registered step/wrap/error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      prev_r        <= ZERO_VAL;
      resync_r      <= 4'd0;
      enable_out    <= 1'b0;
      direction_out <= 1'b0;
      wrap_out      <= 1'b0;
      err_out       <= 1'b0;
      locked        <= 1'b0;
      err_cnt       <= 8'd0;
    end else begin
      enable_out <= 1'b0;
      wrap_out   <= 1'b0;
      err_out    <= 1'b0;
      if (valid_in) begin
        prev_r <= count_in;
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_TRACK;
            locked  <= 1'b1;
          end
          ST_TRACK: begin
            if (is_up_s) begin
              enable_out    <= 1'b1;
              direction_out <= 1'b1;
              wrap_out      <= (prev_r == MAX_VAL);
            end else if (is_dn_s) begin
              enable_out    <= 1'b1;
              direction_out <= 1'b0;
              wrap_out      <= (prev_r == ZERO_VAL);
            end else if (!is_zero_s) begin
              err_out  <= 1'b1;
              err_cnt  <= err_cnt_inc_s;
              resync_r <= 4'd0;
              state_r  <= ST_FAULT;
              locked   <= 1'b0;
            end else begin
              state_r <= ST_TRACK;
            end
          end
          ST_FAULT: begin
            if (legal_s) begin
              if (resync_inc_s >= RESYNC_TGT) begin
                resync_r <= 4'd0;
                state_r  <= ST_TRACK;
                locked   <= 1'b1;
              end else begin
                resync_r <= resync_inc_s;
              end
            end else begin
              err_out  <= 1'b1;
              err_cnt  <= err_cnt_inc_s;
              resync_r <= 4'd0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef DECODER_STALL_CHECK_EN
  logic [7:0] stall_cnt_r;
  logic [7:0] stall_next_s;

  // Saturating next value of the zero-delta run length.
  always_comb begin
    if (stall_cnt_r >= 8'(STALL_LIMIT)) begin
      stall_next_s = stall_cnt_r;
    end else begin
      stall_next_s = stall_cnt_r + 8'd1;
    end
  end

  // Zero-delta run counter; any other valid sample ends the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 8'd0;
      stall_out   <= 1'b0;
    end else if (valid_in && (state_r == ST_TRACK) && is_zero_s) begin
      stall_cnt_r <= stall_next_s;
      stall_out   <= (stall_next_s >= 8'(STALL_LIMIT));
    end else if (valid_in) begin
      stall_cnt_r <= 8'd0;
      stall_out   <= 1'b0;
    end else begin
      stall_cnt_r <= stall_cnt_r;
      stall_out   <= stall_out;
    end
  end
`else
  assign stall_out = 1'b0;
`endif

endmodule

// File: tb/tb_count_stream_decoder.sv
// Directed self-checking bench for count_stream_decoder; expected values are hand-derived.
module tb_count_stream_decoder;

`ifdef DECODER_STALL_CHECK_EN
  localparam logic STALL_EN = 1'b1;
`else
  localparam logic STALL_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] count_in;
  logic       valid_in;
  logic       enable_out;
  logic       direction_out;
  logic       wrap_out;
  logic       err_out;
  logic       locked;
  logic [7:0] err_cnt;
  logic       stall_out;

  int n_checks;
  int n_fail;

  count_stream_decoder #(.WIDTH(8), .RESYNC_LEN(4), .STALL_LIMIT(16)) dut (
    .clk(clk),
    .rst(rst),
    .count_in(count_in),
    .valid_in(valid_in),
    .enable_out(enable_out),
    .direction_out(direction_out),
    .wrap_out(wrap_out),
    .err_out(err_out),
    .locked(locked),
    .err_cnt(err_cnt),
    .stall_out(stall_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of input, then settle just after the edge.
  task automatic step(input logic v, input logic [7:0] c);
    valid_in = v;
    count_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    valid_in = 1'b0;
    count_in = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    valid_in = 1'b0;
    count_in = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_locked", {7'd0, locked}, 8'd0);
    chk("rst_enable", {7'd0, enable_out}, 8'd0);
    chk("rst_dir", {7'd0, direction_out}, 8'd0);
    chk("rst_wrap", {7'd0, wrap_out}, 8'd0);
    chk("rst_err", {7'd0, err_out}, 8'd0);
    chk("rst_errcnt", err_cnt, 8'd0);
    chk("rst_stall", {7'd0, stall_out}, 8'd0);
    rst = 1'b0;

    // 1: capture then two up steps
    step(1'b1, 8'h05);
    chk("t1_lock", {7'd0, locked}, 8'd1);
    chk("t1_en0", {7'd0, enable_out}, 8'd0);
    step(1'b1, 8'h06);
    chk("t1_en1", {6'd0, enable_out, direction_out}, 8'd3);
    step(1'b1, 8'h07);
    chk("t1_en2", {6'd0, enable_out, direction_out}, 8'd3);
    chk("t1_wrap", {7'd0, wrap_out}, 8'd0);

    // 2: wrap up and wrap down
    do_reset();
    step(1'b1, 8'hFE);
    step(1'b1, 8'hFF);
    chk("t2_up", {5'd0, enable_out, direction_out, wrap_out}, 8'd6);
    step(1'b1, 8'h00);
    chk("t2_wrapup", {5'd0, enable_out, direction_out, wrap_out}, 8'd7);
    step(1'b1, 8'hFF);
    chk("t2_wrapdn", {5'd0, enable_out, direction_out, wrap_out}, 8'd5);
    step(1'b1, 8'hFF);
    chk("t2_hold", {5'd0, enable_out, direction_out, wrap_out}, 8'd0);
    step(1'b1, 8'hFE);
    chk("t2_dn", {5'd0, enable_out, direction_out, wrap_out}, 8'd4);

    // 3: illegal jump, resync, restart of resync
    do_reset();
    step(1'b1, 8'h10);
    step(1'b1, 8'h13);
    chk("t3_err", {6'd0, err_out, locked}, 8'd2);
    chk("t3_errcnt", err_cnt, 8'd1);
    chk("t3_en", {7'd0, enable_out}, 8'd0);
    step(1'b1, 8'h14);
    chk("t3_r1", {6'd0, err_out, locked}, 8'd0);
    step(1'b1, 8'h15);
    step(1'b1, 8'h16);
    chk("t3_r3", {7'd0, locked}, 8'd0);
    step(1'b1, 8'h17);
    chk("t3_relock", {6'd0, locked, enable_out}, 8'd2);
    step(1'b1, 8'h19);
    chk("t3_err2", err_cnt, 8'd2);
    step(1'b1, 8'h1A);
    step(1'b1, 8'h1B);
    step(1'b1, 8'h30);
    chk("t3_err3", {7'd0, err_out}, 8'd1);
    chk("t3_errcnt3", err_cnt, 8'd3);
    step(1'b1, 8'h31);
    step(1'b1, 8'h32);
    step(1'b1, 8'h33);
    chk("t3_restart", {7'd0, locked}, 8'd0);
    step(1'b1, 8'h34);
    chk("t3_relock2", {7'd0, locked}, 8'd1);
    step(1'b1, 8'h35);
    chk("t3_track", {6'd0, enable_out, direction_out}, 8'd3);

    // 4: idle gap, then reset mid-FAULT
    do_reset();
    step(1'b1, 8'h1F);
    step(1'b1, 8'h20);
    chk("t4_pre", {7'd0, enable_out}, 8'd1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h77);
      chk("t4_gap", {5'd0, enable_out, wrap_out, err_out}, 8'd0);
    end
    step(1'b1, 8'h21);
    chk("t4_post", {5'd0, enable_out, direction_out, locked}, 8'd7);
    step(1'b1, 8'h50);
    chk("t4_fault", {6'd0, err_out, locked}, 8'd2);
    rst      = 1'b1;
    valid_in = 1'b1;
    count_in = 8'h99;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t4_rst_out", {3'd0, enable_out, direction_out, wrap_out, err_out, locked}, 8'd0);
    chk("t4_rst_cnt", err_cnt, 8'd0);
    step(1'b1, 8'h60);
    chk("t4_recap", {6'd0, locked, enable_out}, 8'd2);
    step(1'b1, 8'h61);
    chk("t4_step", {7'd0, enable_out}, 8'd1);

    // 5: zero-delta run length
    do_reset();
    step(1'b1, 8'h3F);
    step(1'b1, 8'h40);
    chk("t5_step", {6'd0, enable_out, stall_out}, 8'd2);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'h40);
      if (i == 15) chk("t5_stall15", {7'd0, stall_out}, 8'd0);
    end
    chk("t5_stall16", {7'd0, stall_out}, {7'd0, STALL_EN});
    step(1'b1, 8'h40);
    chk("t5_stall_sat", {7'd0, stall_out}, {7'd0, STALL_EN});
    step(1'b1, 8'h41);
    chk("t5_clear", {6'd0, enable_out, stall_out}, 8'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
